// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset constants and buffer entry type for the fetch unit
package fetch_pkg;
    localparam int ADDR_WIDTH = 48;
    localparam int INSTR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 48'd4;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instruction;
        logic [ADDR_WIDTH-1:0]  pc;
    } fetch_entry;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch entries with flush priority and zeroed empty slots
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_entry wr_entry,
    output fetch_entry head,
    output logic [1:0] count
);
    fetch_entry mem0, mem1;
    logic [1:0] pos;

    assign pos = count - {1'b0, pop};
    assign head = mem0;

    // Shift on pop, write at the post-pop tail; mem1 is kept zero unless it holds data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            mem0 <= '0;
            mem1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
            mem0 <= '0;
            mem1 <= '0;
        end else begin
            if (pop) begin
                mem0 <= mem1;
                mem1 <= '0;
            end
            if (push && pos == 2'd0) mem0 <= wr_entry;
            if (push && pos == 2'd1) mem1 <= wr_entry;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencing, redirect handling and decode-side fetch buffer
module instruction_fetch_unit
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_pc
);
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0] count;
    logic push, pop;
    fetch_entry wr_entry, head;

    assign imem_address = pc;
    assign out_valid = count != 2'd0;
    assign pop = out_valid & out_ready;
    assign push = !redirect_valid & (count < 2'd2 | pop);
    assign wr_entry = '{instruction: imem_instruction, pc: pc};
    assign out_instruction = head.instruction;
    assign out_pc = head.pc;

    // Redirect wins and word-aligns the target; otherwise advance only when an entry is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else if (redirect_valid) pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        else if (push) pc <= pc + PC_STEP;
    end

    fetch_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table vectors plus scoreboarded redirect, wrap and reset sequences
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [47:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [47:0] out_pc;

    int total = 0;
    int passed = 0;
    logic [47:0] exp_q[$];

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [47:0] exp_pc;
        logic [47:0] exp_addr;
    } vec_t;
    vec_t vt[10];

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc)
    );

    always #5 clk = ~clk;

    assign imem_instruction = 32'h1000_0000 + imem_address[33:2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic rv, input logic [47:0] rpc);
        logic [47:0] e;
        out_ready = r;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_delivery", {16'h0, out_pc}, 64'hdead);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", {16'h0, out_pc}, {16'h0, e});
                check("sb_instr", {32'h0, out_instruction}, {32'h0, 32'h1000_0000 + e[33:2]});
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1;
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_addr", {16'h0, imem_address}, 64'h0);
        check("rst_pc", {16'h0, out_pc}, 64'h0);
        check("rst_instr", {32'h0, out_instruction}, 64'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drained();
        check("sb_drained", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 48'h00, 48'h00};
        vt[1] = '{1'b1, 1'b1, 48'h00, 48'h04};
        vt[2] = '{1'b1, 1'b1, 48'h04, 48'h08};
        vt[3] = '{1'b1, 1'b1, 48'h08, 48'h0c};
        vt[4] = '{1'b0, 1'b1, 48'h0c, 48'h10};
        vt[5] = '{1'b0, 1'b1, 48'h0c, 48'h14};
        vt[6] = '{1'b0, 1'b1, 48'h0c, 48'h14};
        vt[7] = '{1'b1, 1'b1, 48'h0c, 48'h14};
        vt[8] = '{1'b1, 1'b1, 48'h10, 48'h18};
        vt[9] = '{1'b1, 1'b1, 48'h14, 48'h1c};

        // sequential streaming then backpressure, table driven
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(48'(4 * i));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vt[i].exp_valid});
            check($sformatf("vec%0d_pc", i), {16'h0, out_pc}, {16'h0, vt[i].exp_pc});
            check($sformatf("vec%0d_addr", i), {16'h0, imem_address}, {16'h0, vt[i].exp_addr});
            drive(vt[i].ready, 1'b0, '0);
        end
        drive(1'b0, 1'b0, '0);
        drained();

        // redirect while the buffer is full
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0);
        check("full_head_pc", {16'h0, out_pc}, 64'h0);
        check("full_addr_hold", {16'h0, imem_address}, 64'h8);
        exp_q.push_back(48'h40);
        exp_q.push_back(48'h44);
        drive(1'b0, 1'b1, 48'h40);
        check("redir_bubble", {63'h0, out_valid}, 64'h0);
        check("redir_addr", {16'h0, imem_address}, 64'h40);
        check("redir_pc_zero", {16'h0, out_pc}, 64'h0);
        check("redir_instr_zero", {32'h0, out_instruction}, 64'h0);
        drive(1'b1, 1'b0, '0);
        check("redir_target_valid", {63'h0, out_valid}, 64'h1);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drained();

        // redirect with a simultaneous pop and a misaligned target
        do_reset();
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        exp_q.push_back(48'h0);
        exp_q.push_back(48'h40);
        exp_q.push_back(48'h44);
        drive(1'b1, 1'b1, 48'h42);
        check("mis_bubble", {63'h0, out_valid}, 64'h0);
        check("mis_addr", {16'h0, imem_address}, 64'h40);
        drive(1'b1, 1'b0, '0);
        check("mis_out_pc", {16'h0, out_pc}, 64'h40);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drained();

        // held redirect, then wrap-around at the top of the address space
        do_reset();
        exp_q.push_back(48'hFFFF_FFFF_FFFC);
        exp_q.push_back(48'h0);
        exp_q.push_back(48'h4);
        drive(1'b1, 1'b1, 48'h100);
        check("hold_valid0", {63'h0, out_valid}, 64'h0);
        check("hold_addr0", {16'h0, imem_address}, 64'h100);
        drive(1'b1, 1'b1, 48'hFFFF_FFFF_FFFC);
        check("hold_valid1", {63'h0, out_valid}, 64'h0);
        check("hold_addr1", {16'h0, imem_address}, 64'hFFFF_FFFF_FFFC);
        drive(1'b1, 1'b0, '0);
        check("wrap_addr", {16'h0, imem_address}, 64'h0);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drained();

        // asynchronous reset in the middle of streaming
        do_reset();
        exp_q.push_back(48'h0);
        exp_q.push_back(48'h4);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0);
        check("pre_async_valid", {63'h0, out_valid}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {63'h0, out_valid}, 64'h0);
        check("async_addr", {16'h0, imem_address}, 64'h0);
        check("async_pc", {16'h0, out_pc}, 64'h0);
        check("async_instr", {32'h0, out_instruction}, 64'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(48'h0);
        exp_q.push_back(48'h4);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drained();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Consumer side of the instruction memory interface: owns the program counter and drives the byte address into the combinational instruction_memory.
- Captures the returned 32-bit instruction together with its PC into a 2-entry buffer.
- Presents buffer contents to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes the buffer and restarts fetch at a new PC.

Parameters:
- ADDR_WIDTH, 48, width of PC and instruction memory address.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- imem_address  output  ADDR_WIDTH  byte address to instruction_memory; equals the PC register.
- imem_instruction  input  INSTR_WIDTH  instruction read at imem_address, valid in the same cycle (combinational memory).
- redirect_valid  input  1  load redirect_pc at next edge and flush the buffer.
- redirect_pc  input  ADDR_WIDTH  redirect target.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instruction  output  INSTR_WIDTH  head instruction.
- out_pc  output  ADDR_WIDTH  PC of head instruction.

Behaviour:
- Reset (asynchronous, rst_n low), effective immediately:
  - pc = RESET_PC, so imem_address = RESET_PC.
  - Buffer count = 0, out_valid = 0, out_instruction = 0, out_pc = 0.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < 2 | pop). Registered at the rising edge.
- On push:
  - Entry {imem_instruction, pc} is written at the buffer tail.
  - pc <= pc + PC_STEP, modulo 2^ADDR_WIDTH: 0xFFFF_FFFF_FFFC wraps to 0.
- No push: pc holds, and imem_address stays stable under backpressure.
- Redirect has priority over push and pop:
  - At the edge: pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, so misaligned low bits are forced to zero. Count <= 0.
  - A head entry popped in the redirect cycle counts as consumed. All other entries are discarded.
  - out_valid is 0 in the cycle after the redirect edge (1 bubble). The target instruction is valid the cycle after that.
  - redirect_valid held for several cycles restarts fetch at redirect_pc each cycle; nothing is pushed while it is high.
- Latency: the first instruction becomes valid one edge after rst_n rises. Steady state is one instruction per cycle with out_ready high.
- Full buffer with pop in the same cycle: push and pop both occur, count stays at 2, order is preserved.
- Outputs:
  - out_instruction and out_pc come straight from the head register (no combinational path from imem_instruction).
  - Both read 0 when the buffer is empty.
  - Head contents are stable while out_valid & !out_ready.
- Buffer count is in the range 0..2. Never overflows, never underflows, no duplicate or skipped PCs.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_WIDTH, INSTR_WIDTH, RESET_PC, PC_STEP.
  - NOP_INSTR = 32'h0000_0013.
  - A fetch_entry typedef {instruction, pc}.
- One sub-module, fetch_buffer: 2-entry FIFO of fetch_entry with push, pop and flush; flush has priority. Provides count, head and a registered, zeroed-when-empty output.
- instruction_fetch_unit holds the PC register, push/redirect logic and the fetch_buffer instance.

Test Plan:
- Sequential fetch: memory word at address 4i = 32'h1000_0000+i; reset, then out_ready=1 → out_pc 0,4,8,12… with out_instruction 0x1000_0000, 0x1000_0001…, one per cycle; imem_address advances by 4 each cycle.
- Backpressure: out_ready=0 for 5 cycles after reset → count reaches 2 (pc 0,4), imem_address holds 8, head stays pc 0. Then out_ready=1 → 0,4,8,12 in order with no loss or duplication.
- Redirect while full: redirect_valid=1 with redirect_pc=0x40 for one cycle → next cycle out_valid=0 and imem_address=0x40; following cycle out_pc=0x40, then 0x44.
- Redirect with simultaneous pop: head pc 0 popped in the redirect cycle → pc 0 delivered exactly once, pc 4 discarded, next delivered is the target. Misaligned target 0x42 → delivered out_pc 0x40.
- Wrap-around: redirect to 0xFFFF_FFFF_FFFC → out_pc sequence 0xFFFF_FFFF_FFFC, 0x0, 0x4.
- Mid-operation reset: rst_n driven low between edges while streaming → out_valid=0 and imem_address=RESET_PC immediately, without a clock edge. After release, fetch restarts at pc 0.
